// File: rtl/cmd_icd_pkg.sv
`default_nettype none
// =============================================================================
// cmd_icd_pkg : command word field map, command IDs and executor sizing
// Rev 1.1     : adds bank/output sizing for cmd_exec
// =============================================================================
package cmd_icd_pkg;

  localparam int CMD_W = 32;

  localparam int ID_MSB          = 31;
  localparam int ID_LSB          = 28;
  localparam int BANK_RSV_HI_MSB = 27;
  localparam int BANK_RSV_HI_LSB = 16;
  localparam int BANK_VAL_MSB    = 15;
  localparam int BANK_VAL_LSB    = 8;
  localparam int BANK_RSV_LO_MSB = 7;
  localparam int BANK_RSV_LO_LSB = 4;
  localparam int BANK_EN_MSB     = 3;
  localparam int BANK_EN_LSB     = 0;
  localparam int OUT_RSV_MSB     = 27;
  localparam int OUT_RSV_LSB     = 5;
  localparam int OUT_PAT_MSB     = 4;
  localparam int OUT_PAT_LSB     = 0;

  localparam int NUM_BANKS   = 4;
  localparam int BANK_VAL_W  = 8;
  localparam int OUT_W       = 5;
  localparam int ERR_CNT_W   = 8;
  localparam int PULSE_CNT_W = 8;

  typedef enum logic [3:0] {
    CMD_BANK = 4'b0000,
    CMD_OUT  = 4'b0001
  } cmd_id_t;

  // True when every bit of word within [msb:lsb] is zero.
  function automatic logic field_zero(input logic [CMD_W-1:0] word,
                                      input int msb, input int lsb);
    logic zero;
    zero = 1'b1;
    for (int i = 0; i < CMD_W; i++) begin
      if (i >= lsb && i <= msb && word[i]) zero = 1'b0;
    end
    return zero;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_exec_if.sv
`default_nettype none
// =============================================================================
// cmd_exec_if : valid/ready command word channel into cmd_exec
// Rev 1.0     : initial release
// =============================================================================
interface cmd_exec_if;
  import cmd_icd_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [CMD_W-1:0] cmd_data;

  modport master (output cmd_valid, output cmd_data, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_data, output cmd_ready);

endinterface
`default_nettype wire

// File: rtl/cmd_pulse_timer.sv
`default_nettype none
// =============================================================================
// cmd_pulse_timer : load / count-down / done timer for the OUT pulse
// Rev 1.0         : initial release
// =============================================================================
module cmd_pulse_timer
  import cmd_icd_pkg::*;
#(
  parameter int OUT_PULSE_CYCLES = 4
) (
  input  wire  clk,
  input  wire  rst_n,
  input  wire  load,
  input  wire  run,
  output logic done
);

  // Loading N-1 makes done coincide with the last pulse cycle.
  localparam logic [PULSE_CNT_W-1:0] LOAD_VAL = PULSE_CNT_W'(OUT_PULSE_CYCLES - 1);

  logic [PULSE_CNT_W-1:0] cnt_q;
  logic [PULSE_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (run && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/cmd_exec.sv
`default_nettype none
// =============================================================================
// cmd_exec : decodes command words into bank writes, OUT pulses and error flags
// Rev 1.0  : initial release
// =============================================================================
module cmd_exec
  import cmd_icd_pkg::*;
#(
  parameter int OUT_PULSE_CYCLES = 4
) (
  input  wire                              clk,
  input  wire                              rst_n,
  cmd_exec_if.slave                        cmd,
  output logic [NUM_BANKS*BANK_VAL_W-1:0]  bank_q,
  output logic [NUM_BANKS-1:0]             bank_upd,
  output logic [OUT_W-1:0]                 out_val,
  output logic                             out_active,
  output logic                             err_pulse,
  output logic [ERR_CNT_W-1:0]             err_count
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } state_t;

  state_t                          state_q, state_d;
  logic [NUM_BANKS*BANK_VAL_W-1:0] banks_q, banks_d;
  logic [NUM_BANKS-1:0]            bank_upd_q, bank_upd_d;
  logic [OUT_W-1:0]                out_val_q, out_val_d;
  logic                            err_pulse_q, err_pulse_d;
  logic [ERR_CNT_W-1:0]            err_count_q, err_count_d;

  logic    accept;
  cmd_id_t cmd_id;
  logic    bank_ok;
  logic    out_ok;
  logic    timer_load;
  logic    timer_done;

  assign cmd.cmd_ready = (state_q == ST_IDLE);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  assign cmd_id  = cmd_id_t'(cmd.cmd_data[ID_MSB:ID_LSB]);
  assign bank_ok = (cmd_id == CMD_BANK)
                && field_zero(cmd.cmd_data, BANK_RSV_HI_MSB, BANK_RSV_HI_LSB)
                && field_zero(cmd.cmd_data, BANK_RSV_LO_MSB, BANK_RSV_LO_LSB);
  assign out_ok  = (cmd_id == CMD_OUT)
                && field_zero(cmd.cmd_data, OUT_RSV_MSB, OUT_RSV_LSB);

  cmd_pulse_timer #(
    .OUT_PULSE_CYCLES (OUT_PULSE_CYCLES)
  ) u_pulse_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (timer_load),
    .run   (state_q == ST_PULSE),
    .done  (timer_done)
  );

  always_comb begin
    state_d     = state_q;
    banks_d     = banks_q;
    bank_upd_d  = '0;
    out_val_d   = out_val_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    timer_load  = 1'b0;

    if (accept) begin
      if (bank_ok) begin
        for (int i = 0; i < NUM_BANKS; i++) begin
          if (cmd.cmd_data[BANK_EN_LSB + i]) begin
            banks_d[i*BANK_VAL_W +: BANK_VAL_W] = cmd.cmd_data[BANK_VAL_MSB:BANK_VAL_LSB];
            bank_upd_d[i]                       = 1'b1;
          end
        end
      end else if (out_ok) begin
        out_val_d  = cmd.cmd_data[OUT_PAT_MSB:OUT_PAT_LSB];
        state_d    = ST_PULSE;
        timer_load = 1'b1;
      end else begin
        err_pulse_d = 1'b1;
        if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
      end
    end

    // Accepts only happen in IDLE, so pulse exit never races a new load.
    if (state_q == ST_PULSE && timer_done) begin
      state_d   = ST_IDLE;
      out_val_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      banks_q     <= '0;
      bank_upd_q  <= '0;
      out_val_q   <= '0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      banks_q     <= banks_d;
      bank_upd_q  <= bank_upd_d;
      out_val_q   <= out_val_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign bank_q     = banks_q;
  assign bank_upd   = bank_upd_q;
  assign out_val    = out_val_q;
  assign out_active = (state_q == ST_PULSE);
  assign err_pulse  = err_pulse_q;
  assign err_count  = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_cmd_exec.sv
`default_nettype none
// =============================================================================
// tb_cmd_exec : directed self-checking bench for cmd_exec
// Rev 1.0     : initial release
// =============================================================================
module tb_cmd_exec;

  localparam int PULSE = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] bank_q;
  logic [3:0]  bank_upd;
  logic [4:0]  out_val;
  logic        out_active;
  logic        err_pulse;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  cmd_exec_if cmd_if ();

  cmd_exec #(
    .OUT_PULSE_CYCLES (PULSE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd        (cmd_if),
    .bank_q     (bank_q),
    .bank_upd   (bank_upd),
    .out_val    (out_val),
    .out_active (out_active),
    .err_pulse  (err_pulse),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] d);
    cmd_if.cmd_valid = v;
    cmd_if.cmd_data  = d;
  endtask

  initial begin
    drive(1'b0, 32'h0);
    rst_n = 1'b0;
    repeat (2) step();
    chk("rst_bank_q",    bank_q,              32'h0);
    chk("rst_bank_upd",  32'(bank_upd),       32'h0);
    chk("rst_out_val",   32'(out_val),        32'h0);
    chk("rst_out_act",   32'(out_active),     32'h0);
    chk("rst_err_pulse", 32'(err_pulse),      32'h0);
    chk("rst_err_count", 32'(err_count),      32'h0);
    chk("rst_ready",     32'(cmd_if.cmd_ready), 32'h1);
    rst_n = 1'b1;
    step();

    // Banks 0 and 2 written with 0xA5
    drive(1'b1, 32'h0000_A505);
    step();
    chk("bank_wr_q",   bank_q,        32'h00A5_00A5);
    chk("bank_wr_upd", 32'(bank_upd), 32'h5);
    chk("bank_wr_err", 32'(err_pulse), 32'h0);
    drive(1'b0, 32'h0);
    step();
    chk("bank_upd_once", 32'(bank_upd), 32'h0);
    chk("bank_hold",     bank_q,        32'h00A5_00A5);

    // Enable mask 0: legal no-op
    drive(1'b1, 32'h0000_7700);
    step();
    chk("mask0_upd", 32'(bank_upd),  32'h0);
    chk("mask0_err", 32'(err_pulse), 32'h0);
    chk("mask0_q",   bank_q,         32'h00A5_00A5);
    drive(1'b0, 32'h0);
    step();

    // OUT pulse, with a BANK word stalled behind it
    drive(1'b1, 32'h1000_0013);
    step();
    drive(1'b1, 32'h0000_3C02);
    for (int i = 0; i < PULSE; i++) begin
      chk("pulse_val",   32'(out_val),          32'h13);
      chk("pulse_act",   32'(out_active),       32'h1);
      chk("pulse_ready", 32'(cmd_if.cmd_ready), 32'h0);
      step();
    end
    chk("pulse_end_ready", 32'(cmd_if.cmd_ready), 32'h1);
    chk("pulse_end_act",   32'(out_active),       32'h0);
    chk("pulse_end_val",   32'(out_val),          32'h0);
    chk("stall_no_upd",    32'(bank_upd),         32'h0);
    step();
    chk("after_pulse_upd", 32'(bank_upd), 32'h2);
    chk("after_pulse_q",   bank_q,        32'h00A5_3CA5);
    drive(1'b0, 32'h0);
    step();

    // Zero pattern still pulses
    drive(1'b1, 32'h1000_0000);
    step();
    drive(1'b0, 32'h0);
    for (int i = 0; i < PULSE; i++) begin
      chk("pat0_act",   32'(out_active),       32'h1);
      chk("pat0_val",   32'(out_val),          32'h0);
      chk("pat0_ready", 32'(cmd_if.cmd_ready), 32'h0);
      step();
    end
    chk("pat0_end_act",   32'(out_active),       32'h0);
    chk("pat0_end_ready", 32'(cmd_if.cmd_ready), 32'h1);

    // Reserved bits set, then unknown ID
    drive(1'b1, 32'h0000_A5F1);
    step();
    chk("err1_pulse", 32'(err_pulse), 32'h1);
    chk("err1_count", 32'(err_count), 32'h1);
    drive(1'b1, 32'h2000_0000);
    step();
    chk("err2_pulse", 32'(err_pulse), 32'h1);
    chk("err2_count", 32'(err_count), 32'h2);
    drive(1'b0, 32'h0);
    step();
    chk("err_idle_pulse", 32'(err_pulse),  32'h0);
    chk("err_idle_count", 32'(err_count),  32'h2);
    chk("err_bank_q",     bank_q,          32'h00A5_3CA5);
    chk("err_out_act",    32'(out_active), 32'h0);
    chk("err_bank_upd",   32'(bank_upd),   32'h0);

    // Saturation over 260 back-to-back error words
    drive(1'b1, 32'h3000_0000);
    for (int j = 1; j <= 260; j++) begin
      step();
      chk("sat_pulse", 32'(err_pulse), 32'h1);
      chk("sat_count", 32'(err_count), (2 + j > 255) ? 32'd255 : 32'(2 + j));
    end
    drive(1'b0, 32'h0);
    step();
    chk("sat_idle_pulse", 32'(err_pulse), 32'h0);
    chk("sat_idle_count", 32'(err_count), 32'd255);

    // Reset asserted in the 2nd cycle of a pulse
    drive(1'b1, 32'h1000_001F);
    step();
    drive(1'b0, 32'h0);
    chk("rp_act_c1", 32'(out_active), 32'h1);
    chk("rp_val_c1", 32'(out_val),    32'h1F);
    step();
    rst_n = 1'b0;
    #1;
    chk("rp_act_rst",   32'(out_active),       32'h0);
    chk("rp_val_rst",   32'(out_val),          32'h0);
    chk("rp_ready_rst", 32'(cmd_if.cmd_ready), 32'h1);
    chk("rp_bank_rst",  bank_q,                32'h0);
    chk("rp_cnt_rst",   32'(err_count),        32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("rp_ready_rel", 32'(cmd_if.cmd_ready), 32'h1);
    chk("rp_act_rel",   32'(out_active),       32'h0);
    chk("rp_bank_rel",  bank_q,                32'h0);

    // Back-to-back BANK words
    drive(1'b1, 32'h0000_1101);
    chk("b2b_ready0", 32'(cmd_if.cmd_ready), 32'h1);
    step();
    chk("b2b_bank0_a", 32'(bank_q[7:0]),      32'h11);
    chk("b2b_upd_a",   32'(bank_upd),         32'h1);
    chk("b2b_ready1",  32'(cmd_if.cmd_ready), 32'h1);
    drive(1'b1, 32'h0000_2201);
    step();
    chk("b2b_bank0_b", 32'(bank_q[7:0]),      32'h22);
    chk("b2b_upd_b",   32'(bank_upd),         32'h1);
    chk("b2b_ready2",  32'(cmd_if.cmd_ready), 32'h1);
    drive(1'b0, 32'h0);
    step();
    chk("b2b_upd_end", 32'(bank_upd), 32'h0);
    chk("b2b_q_end",   bank_q,        32'h0000_0022);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
